match_scorer: RTL and testbench
===============================

Name: match_scorer

Overview:
- Receive end of the serialized match stream. Consumes the one-event-per-cycle (match_en, match_dt) stream from the buffer serializer, plus a miss strobe from the note-expiry logic.
- Grades each hit by timing error and keeps the score, combo, multiplier and max-combo registers.
- Emits a judgement pulse that drives the on-screen "PERFECT/GREAT/GOOD/MISS" popup.
- Sits between the serializer and the score/HUD display logic.

Parameters:
- PERFECT_DT, 16'd20: max |dt| in song_time ticks graded PERFECT.
- GREAT_DT, 16'd40: max |dt| graded GREAT.
- GOOD_DT, 16'd80: max |dt| graded GOOD; above this a hit grades MISS.
- PTS_PERFECT, 8'd100: base points for PERFECT.
- PTS_GREAT, 8'd50: base points for GREAT.
- PTS_GOOD, 8'd20: base points for GOOD.
- COMBO_STEP, 10: consecutive hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous song-start clear.
- match_en  in  1  valid strobe for match_dt, one cycle per event.
- match_dt  in  16  unsigned absolute timing error of the hit.
- miss_en  in  1  a note scrolled past unhit, one cycle per note.
- score  out  24  accumulated score.
- combo  out  10  current consecutive-hit count.
- max_combo  out  10  highest combo this song.
- multiplier  out  3  current multiplier, 1..MAX_MULT.
- judge_valid  out  1  one-cycle pulse per graded event.
- judge  out  2  0=MISS, 1=GOOD, 2=GREAT, 3=PERFECT; valid with judge_valid.

Behaviour:
- Reset (rst_n low, async): score, combo, max_combo, judge, judge_valid, pipeline valids, step counter = 0; multiplier = 1.
- clear (sync): same values as reset and flushes both pipeline stages. clear wins over match_en/miss_en in the same cycle. Events already in flight are dropped with no judge_valid.
- Stage 1 (cycle N+1 after input at N): register the tier.
  - dt<=PERFECT_DT -> 3; else dt<=GREAT_DT -> 2; else dt<=GOOD_DT -> 1; else 0. Comparisons are inclusive and unsigned.
  - Also register the hit-valid bit, the miss bit (miss_en OR tier 0) and base points.
- Stage 2 (cycle N+2): apply the update. score/combo/multiplier/judge_valid change at N+2; fixed latency is 2 cycles, fully pipelined, one event per cycle sustained.
- Hit (tier 1..3, no miss):
  - score += base_pts * multiplier, using the pre-update multiplier. The 24-bit sum saturates at 24'hFFFFFF.
  - combo += 1, saturating at 1023.
  - max_combo = max(max_combo, new combo).
  - Step counter (0..COMBO_STEP-1) increments. On wrap to 0, multiplier += 1 if multiplier < MAX_MULT. The counter still wraps once multiplier is at MAX_MULT.
  - judge = tier.
- Miss (miss_en, or hit graded 0): score unchanged; combo = 0; step = 0; multiplier = 1; max_combo unchanged; judge = 0.
- match_en and miss_en in the same cycle:
  - A valid hit (tier>=1) is scored first: its points at the current multiplier, and max_combo updated with combo+1.
  - The miss then applies: combo=0, multiplier=1, step=0.
  - A single judge_valid pulse fires with judge = 0.
- judge_valid is exactly one cycle per input cycle containing match_en or miss_en; it is never stretched.
- No division: the multiplier is tracked only via the step counter.

Test Plan:
- Reset: pulse rst_n low mid-stream -> all outputs 0 immediately (async), multiplier=1, no judge_valid afterwards for pre-reset events.
- Single hit: match_en with dt=15 at cycle N -> cycle N+2: judge_valid=1, judge=3, score=100, combo=1, max_combo=1, multiplier=1.
- Multiplier ramp: 11 back-to-back hits with dt=0 -> multiplier=2 after the 10th; the 11th adds 200; final score=1200, combo=11.
- Grading boundaries: dt=20/21/40/41/80/81 -> judge 3/2/2/1/1/0. The dt=81 hit resets combo to 0 and multiplier to 1; score unchanged by it.
- Simultaneous: with combo=5, multiplier=1, send match_en dt=30 together with miss_en -> score+50, combo=0, max_combo=6, judge=0, single judge_valid.
- Clear in flight: match_en dt=0 at N, clear at N+1 -> no judge_valid at N+2; score=0, multiplier=1. Also preload score near 24'hFFFFFF and hit -> saturates at 24'hFFFFFF.

Source files
------------

// File: rtl/match_scorer_if.sv
// Bundles the scorer's event inputs (hit/miss strobes, song-start clear) and its
// score/HUD outputs so the serializer side and the display side share one bus.
interface match_scorer_if;
  logic        clear;
  logic        match_en;
  logic [15:0] match_dt;
  logic        miss_en;
  logic [23:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic [2:0]  multiplier;
  logic        judge_valid;
  logic [1:0]  judge;

  modport master (
    output clear, match_en, match_dt, miss_en,
    input  score, combo, max_combo, multiplier, judge_valid, judge
  );

  modport slave (
    input  clear, match_en, match_dt, miss_en,
    output score, combo, max_combo, multiplier, judge_valid, judge
  );
endinterface

// File: rtl/match_scorer.sv
// Two-stage rhythm-game scorer: stage 1 grades each hit by timing error, stage 2
// applies score/combo/multiplier updates and pulses the judgement for the HUD popup.
module match_scorer #(
  parameter logic [15:0] PERFECT_DT  = 16'd20,
  parameter logic [15:0] GREAT_DT    = 16'd40,
  parameter logic [15:0] GOOD_DT     = 16'd80,
  parameter logic [7:0]  PTS_PERFECT = 8'd100,
  parameter logic [7:0]  PTS_GREAT   = 8'd50,
  parameter logic [7:0]  PTS_GOOD    = 8'd20,
  parameter int          COMBO_STEP  = 10,
  parameter int          MAX_MULT    = 4
) (
  input logic           clk,
  input logic           rst_n,
  match_scorer_if.slave bus
);

  localparam int STEP_W = (COMBO_STEP > 1) ? $clog2(COMBO_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(COMBO_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [2:0]        MULT_MAX  = 3'(MAX_MULT);

  logic [1:0]        w_tier;
  logic [7:0]        w_pts;

  logic              r_s1_valid;
  logic              r_s1_hit;
  logic              r_s1_miss;
  logic [1:0]        r_s1_tier;
  logic [7:0]        r_s1_pts;

  logic [23:0]       r_score;
  logic [9:0]        r_combo;
  logic [9:0]        r_max_combo;
  logic [2:0]        r_mult;
  logic [STEP_W-1:0] r_step;
  logic              r_judge_valid;
  logic [1:0]        r_judge;

  logic [10:0]       w_add;
  logic [24:0]       w_sum;
  logic [9:0]        w_combo_inc;
  logic [23:0]       w_score_n;
  logic [9:0]        w_combo_n;
  logic [9:0]        w_max_n;
  logic [2:0]        w_mult_n;
  logic [STEP_W-1:0] w_step_n;

  // Inclusive unsigned thresholds, tightest window first.
  always_comb begin
    w_tier = 2'd0;
    w_pts  = 8'd0;
    if (bus.match_dt <= PERFECT_DT) begin
      w_tier = 2'd3;
      w_pts  = PTS_PERFECT;
    end else if (bus.match_dt <= GREAT_DT) begin
      w_tier = 2'd2;
      w_pts  = PTS_GREAT;
    end else if (bus.match_dt <= GOOD_DT) begin
      w_tier = 2'd1;
      w_pts  = PTS_GOOD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_miss  <= 1'b0;
      r_s1_tier  <= 2'd0;
      r_s1_pts   <= 8'd0;
    end else if (bus.clear) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_miss  <= 1'b0;
      r_s1_tier  <= 2'd0;
      r_s1_pts   <= 8'd0;
    end else begin
      r_s1_valid <= bus.match_en | bus.miss_en;
      r_s1_hit   <= bus.match_en && (w_tier != 2'd0);
      r_s1_miss  <= bus.miss_en || (bus.match_en && (w_tier == 2'd0));
      r_s1_tier  <= w_tier;
      r_s1_pts   <= w_pts;
    end
  end

  assign w_add       = {3'b000, r_s1_pts} * {8'h00, r_mult};
  assign w_sum       = {1'b0, r_score} + {14'd0, w_add};
  assign w_combo_inc = (r_combo == 10'd1023) ? r_combo : r_combo + 10'd1;

  // A hit scores first at the old multiplier; a concurrent miss then wipes the streak.
  always_comb begin
    w_score_n = r_score;
    w_combo_n = r_combo;
    w_max_n   = r_max_combo;
    w_mult_n  = r_mult;
    w_step_n  = r_step;
    if (r_s1_hit) begin
      w_score_n = w_sum[24] ? 24'hFFFFFF : w_sum[23:0];
      w_combo_n = w_combo_inc;
      if (w_combo_inc > r_max_combo) begin
        w_max_n = w_combo_inc;
      end
      if (r_step == STEP_LAST) begin
        w_step_n = '0;
        if (r_mult < MULT_MAX) begin
          w_mult_n = r_mult + 3'd1;
        end
      end else begin
        w_step_n = r_step + STEP_ONE;
      end
    end
    if (r_s1_miss) begin
      w_combo_n = 10'd0;
      w_mult_n  = 3'd1;
      w_step_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score       <= 24'd0;
      r_combo       <= 10'd0;
      r_max_combo   <= 10'd0;
      r_mult        <= 3'd1;
      r_step        <= '0;
      r_judge_valid <= 1'b0;
      r_judge       <= 2'd0;
    end else if (bus.clear) begin
      r_score       <= 24'd0;
      r_combo       <= 10'd0;
      r_max_combo   <= 10'd0;
      r_mult        <= 3'd1;
      r_step        <= '0;
      r_judge_valid <= 1'b0;
      r_judge       <= 2'd0;
    end else begin
      r_score       <= w_score_n;
      r_combo       <= w_combo_n;
      r_max_combo   <= w_max_n;
      r_mult        <= w_mult_n;
      r_step        <= w_step_n;
      r_judge_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_judge <= r_s1_miss ? 2'd0 : r_s1_tier;
      end
    end
  end

  assign bus.score       = r_score;
  assign bus.combo       = r_combo;
  assign bus.max_combo   = r_max_combo;
  assign bus.multiplier  = r_mult;
  assign bus.judge_valid = r_judge_valid;
  assign bus.judge       = r_judge;

endmodule

// File: tb/tb_match_scorer.sv
// Directed bench for match_scorer: grading windows, multiplier ramp, combined
// hit+miss, clear of in-flight events, async reset and score saturation.
module tb_match_scorer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  match_scorer_if bus();

  match_scorer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one event so the next rising edge captures it, then returns 1 ns after that edge.
  task automatic applyStimulus(input logic en, input logic [15:0] dt, input logic miss);
    bus.match_en = en;
    bus.match_dt = dt;
    bus.miss_en  = miss;
    @(posedge clk);
    #1;
    bus.match_en = 1'b0;
    bus.match_dt = 16'd0;
    bus.miss_en  = 1'b0;
  endtask

  task automatic doClear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.score !== 24'd0) begin
      failures++; $display("[TB] FAIL reset_score: got %0d expected 0", bus.score);
    end
    checks++;
    if (bus.combo !== 10'd0 || bus.max_combo !== 10'd0) begin
      failures++; $display("[TB] FAIL reset_combo: got %0d/%0d expected 0/0", bus.combo, bus.max_combo);
    end
    checks++;
    if (bus.multiplier !== 3'd1) begin
      failures++; $display("[TB] FAIL reset_mult: got %0d expected 1", bus.multiplier);
    end
    checks++;
    if (bus.judge_valid !== 1'b0 || bus.judge !== 2'd0) begin
      failures++; $display("[TB] FAIL reset_judge: got %0b/%0d expected 0/0", bus.judge_valid, bus.judge);
    end
  endtask

  task automatic test_single_hit();
    applyStimulus(1'b1, 16'd15, 1'b0);
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL single_early_valid: got %0b expected 0", bus.judge_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge !== 2'd3) begin
      failures++; $display("[TB] FAIL single_judge: got %0b/%0d expected 1/3", bus.judge_valid, bus.judge);
    end
    checks++;
    if (bus.score !== 24'd100) begin
      failures++; $display("[TB] FAIL single_score: got %0d expected 100", bus.score);
    end
    checks++;
    if (bus.combo !== 10'd1 || bus.max_combo !== 10'd1 || bus.multiplier !== 3'd1) begin
      failures++; $display("[TB] FAIL single_combo: got %0d/%0d/%0d expected 1/1/1", bus.combo, bus.max_combo, bus.multiplier);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL single_pulse_width: got %0b expected 0", bus.judge_valid);
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b1, 16'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.score !== 24'd0 || bus.combo !== 10'd0 || bus.max_combo !== 10'd0) begin
      failures++; $display("[TB] FAIL async_reset_state: got %0d/%0d/%0d expected 0/0/0", bus.score, bus.combo, bus.max_combo);
    end
    checks++;
    if (bus.multiplier !== 3'd1 || bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset_mult: got %0d/%0b expected 1/0", bus.multiplier, bus.judge_valid);
    end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.judge_valid !== 1'b0 || bus.score !== 24'd0) begin
        failures++; $display("[TB] FAIL reset_drops_event: cycle %0d got %0b/%0d expected 0/0", i, bus.judge_valid, bus.score);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic expValid;
    doClear();
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.match_en = (cyc < 11);
      bus.match_dt = 16'd0;
      @(posedge clk); #1;
      expValid = (cyc >= 1);
      checks++;
      if (bus.judge_valid !== expValid) begin
        failures++; $display("[TB] FAIL b2b_valid: cycle %0d got %0b expected %0b", cyc, bus.judge_valid, expValid);
      end
      if (cyc == 10) begin
        checks++;
        if (bus.multiplier !== 3'd2 || bus.score !== 24'd1000 || bus.combo !== 10'd10) begin
          failures++; $display("[TB] FAIL ramp_tenth: got mult %0d score %0d combo %0d expected 2/1000/10", bus.multiplier, bus.score, bus.combo);
        end
      end
    end
    bus.match_en = 1'b0;
    checks++;
    if (bus.score !== 24'd1200 || bus.combo !== 10'd11 || bus.max_combo !== 10'd11 || bus.multiplier !== 3'd2) begin
      failures++; $display("[TB] FAIL ramp_final: got score %0d combo %0d max %0d mult %0d expected 1200/11/11/2", bus.score, bus.combo, bus.max_combo, bus.multiplier);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_tail: got %0b expected 0", bus.judge_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] dts   [6] = '{16'd20, 16'd21, 16'd40, 16'd41, 16'd80, 16'd81};
    logic [1:0]  tiers [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [23:0] scores[6] = '{24'd100, 24'd150, 24'd200, 24'd220, 24'd240, 24'd240};
    doClear();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, dts[i], 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.judge_valid !== 1'b1 || bus.judge !== tiers[i]) begin
        failures++; $display("[TB] FAIL boundary_judge dt=%0d: got %0b/%0d expected 1/%0d", dts[i], bus.judge_valid, bus.judge, tiers[i]);
      end
      checks++;
      if (bus.score !== scores[i]) begin
        failures++; $display("[TB] FAIL boundary_score dt=%0d: got %0d expected %0d", dts[i], bus.score, scores[i]);
      end
    end
    checks++;
    if (bus.combo !== 10'd0 || bus.multiplier !== 3'd1 || bus.max_combo !== 10'd5) begin
      failures++; $display("[TB] FAIL boundary_miss_state: got combo %0d mult %0d max %0d expected 0/1/5", bus.combo, bus.multiplier, bus.max_combo);
    end
  endtask

  task automatic test_simultaneous();
    doClear();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'd0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.score !== 24'd500 || bus.combo !== 10'd5) begin
      failures++; $display("[TB] FAIL simul_setup: got score %0d combo %0d expected 500/5", bus.score, bus.combo);
    end
    applyStimulus(1'b1, 16'd30, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b1 || bus.judge !== 2'd0) begin
      failures++; $display("[TB] FAIL simul_judge: got %0b/%0d expected 1/0", bus.judge_valid, bus.judge);
    end
    checks++;
    if (bus.score !== 24'd550 || bus.combo !== 10'd0 || bus.max_combo !== 10'd6 || bus.multiplier !== 3'd1) begin
      failures++; $display("[TB] FAIL simul_state: got score %0d combo %0d max %0d mult %0d expected 550/0/6/1", bus.score, bus.combo, bus.max_combo, bus.multiplier);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL simul_single_pulse: got %0b expected 0", bus.judge_valid);
    end
  endtask

  task automatic test_clear_in_flight();
    applyStimulus(1'b1, 16'd0, 1'b0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL clear_drops_valid: got %0b expected 0", bus.judge_valid);
    end
    checks++;
    if (bus.score !== 24'd0 || bus.multiplier !== 3'd1 || bus.combo !== 10'd0 || bus.max_combo !== 10'd0) begin
      failures++; $display("[TB] FAIL clear_state: got score %0d mult %0d combo %0d max %0d expected 0/1/0/0", bus.score, bus.multiplier, bus.combo, bus.max_combo);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.judge_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL clear_no_late_valid: got %0b expected 0", bus.judge_valid);
    end
  endtask

  // 30 ramp hits give 6000; 41928 more at x4 land on 16777200, one step short of wrap.
  task automatic test_saturation();
    doClear();
    bus.match_en = 1'b1;
    bus.match_dt = 16'd0;
    repeat (41958) @(posedge clk);
    #1;
    bus.match_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.score !== 24'hFFFFF0 || bus.multiplier !== 3'd4) begin
      failures++; $display("[TB] FAIL sat_preload: got score %0h mult %0d expected fffff0/4", bus.score, bus.multiplier);
    end
    checks++;
    if (bus.combo !== 10'd1023 || bus.max_combo !== 10'd1023) begin
      failures++; $display("[TB] FAIL combo_saturate: got %0d/%0d expected 1023/1023", bus.combo, bus.max_combo);
    end
    applyStimulus(1'b1, 16'd0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.score !== 24'hFFFFFF) begin
      failures++; $display("[TB] FAIL score_saturate: got %0h expected ffffff", bus.score);
    end
    applyStimulus(1'b1, 16'd35, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.score !== 24'hFFFFFF || bus.judge !== 2'd2) begin
      failures++; $display("[TB] FAIL score_stays_saturated: got %0h/%0d expected ffffff/2", bus.score, bus.judge);
    end
  endtask

  // Scenarios run in order; each leaves the inputs idle for the next.
  initial begin
    checks       = 0;
    failures     = 0;
    bus.clear    = 1'b0;
    bus.match_en = 1'b0;
    bus.match_dt = 16'd0;
    bus.miss_en  = 1'b0;
    rst_n        = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_hit();
    test_reset_midstream();
    test_back_to_back();
    test_boundaries();
    test_simultaneous();
    test_clear_in_flight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
